// File: rtl/ms_stopwatch_if.sv
// Button/tick inputs and BCD display outputs of the millisecond stopwatch.
// The master drives the pulses and the slave (the stopwatch) drives the display.
interface ms_stopwatch_if;
  logic        tick_ms;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [11:0] ms_bcd;
  logic [7:0]  sec_bcd;
  logic [7:0]  min_bcd;
  logic        running;
  logic        ovf;

  modport master (
    output tick_ms, start_stop, clear, lap,
    input  ms_bcd, sec_bcd, min_bcd, running, ovf
  );

  modport slave (
    input  tick_ms, start_stop, clear, lap,
    output ms_bcd, sec_bcd, min_bcd, running, ovf
  );
endinterface

// File: rtl/ms_stopwatch.sv
// BCD MM:SS.mmm stopwatch counting 1 ms tick pulses, saturating at MAX_MIN:59.999.
// Optional display lap hold is enabled by defining LAP_HOLD_EN.
module ms_stopwatch #(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic           clk,
  input  logic           reset,
  ms_stopwatch_if.slave  bus
);

  localparam int unsigned NDIG = 7;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  // Digit 0 is ms units, digit 6 is minutes tens.
  typedef logic [NDIG-1:0][3:0] digits_t;

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MU = 4'(MAX_MIN % 10);
  localparam digits_t    LIMIT  = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};
  localparam digits_t    SAT    = {MAX_MT, MAX_MU, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

  state_t  state_q, state_d;
  digits_t cnt_q, cnt_d;
  digits_t disp_q, disp_d;
  logic    running_q, running_d;
  logic    ovf_q, ovf_d;
  digits_t inc;
  logic    carry;
  logic    tick_ok;
  logic    at_sat;

`ifdef LAP_HOLD_EN
  logic    hold_q, hold_d;
`else
  logic    unused_lap;
  assign unused_lap = bus.lap;
`endif

  // Next state, cascaded BCD increment and display hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    inc       = cnt_q;
    carry     = 1'b1;
    tick_ok   = bus.tick_ms && (state_q == RUN);
    at_sat    = (cnt_q == SAT);

    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (inc[i] == LIMIT[i]) begin
          inc[i] = 4'd0;
        end else begin
          inc[i] = inc[i] + 4'd1;
          carry  = 1'b0;
        end
      end
    end

    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (tick_ok) begin
        if (at_sat) ovf_d = 1'b1;
        else        cnt_d = inc;
      end
      unique case (state_q)
        IDLE:    if (bus.start_stop) state_d = RUN;
        RUN:     if (bus.start_stop || (tick_ok && at_sat)) state_d = PAUSE;
        PAUSE:   if (bus.start_stop && !ovf_q) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);

`ifdef LAP_HOLD_EN
    hold_d = hold_q;
    if (bus.clear)                          hold_d = 1'b0;
    else if (bus.lap && (state_q != IDLE))  hold_d = !hold_q;
    // While held the display keeps the value it showed when the hold began.
    disp_d = hold_d ? disp_q : cnt_d;
`else
    disp_d = cnt_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef LAP_HOLD_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
`ifdef LAP_HOLD_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.ms_bcd  = disp_q[2:0];
  assign bus.sec_bcd = disp_q[4:3];
  assign bus.min_bcd = disp_q[6:5];
  assign bus.running = running_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_ms_stopwatch.sv
// Directed bench for ms_stopwatch: a default instance and a MAX_MIN=1 instance
// for the saturation corner.
module tb_ms_stopwatch;

  logic clk   = 1'b0;
  logic clk_b = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk   = ~clk;
  always #1 clk_b = ~clk_b;

  ms_stopwatch_if a_if ();
  ms_stopwatch_if b_if ();

  ms_stopwatch #(.MAX_MIN(99)) dut_a (.clk(clk),   .reset(rst_a), .bus(a_if.slave));
  ms_stopwatch #(.MAX_MIN(1))  dut_b (.clk(clk_b), .reset(rst_b), .bus(b_if.slave));

  function automatic logic [27:0] cnt_a();
    return {a_if.min_bcd, a_if.sec_bcd, a_if.ms_bcd};
  endfunction

  function automatic logic [27:0] cnt_b();
    return {b_if.min_bcd, b_if.sec_bcd, b_if.ms_bcd};
  endfunction

  // One-cycle pulse on instance A; returns at the negedge after the sampling edge.
  task automatic a_cycle(input logic tk, input logic ss, input logic cl, input logic lp);
    @(negedge clk);
    a_if.tick_ms = tk; a_if.start_stop = ss; a_if.clear = cl; a_if.lap = lp;
    @(negedge clk);
    a_if.tick_ms = 1'b0; a_if.start_stop = 1'b0; a_if.clear = 1'b0; a_if.lap = 1'b0;
  endtask

  task automatic a_ticks(input int n);
    @(negedge clk);
    a_if.tick_ms = 1'b1;
    repeat (n) @(negedge clk);
    a_if.tick_ms = 1'b0;
  endtask

  task automatic b_cycle(input logic tk, input logic ss, input logic cl);
    @(negedge clk_b);
    b_if.tick_ms = tk; b_if.start_stop = ss; b_if.clear = cl;
    @(negedge clk_b);
    b_if.tick_ms = 1'b0; b_if.start_stop = 1'b0; b_if.clear = 1'b0;
  endtask

  task automatic b_ticks(input int n);
    @(negedge clk_b);
    b_if.tick_ms = 1'b1;
    repeat (n) @(negedge clk_b);
    b_if.tick_ms = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL reset_count got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", a_if.running); end
    checks++; if (a_if.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", a_if.ovf); end
    a_ticks(5);
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL idle_ticks got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL idle_running got %b exp 0", a_if.running); end
  endtask

  task automatic test_run_pause();
    a_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL start_tick_uncounted got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", a_if.running); end
    a_ticks(1234);
    checks++; if (cnt_a() !== 28'h0001234) begin errors++; $display("FAIL run_1234 got %h exp %h", cnt_a(), 28'h0001234); end
    a_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_a() !== 28'h0001235) begin errors++; $display("FAIL stop_tick_counted got %h exp %h", cnt_a(), 28'h0001235); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL pause_running got %b exp 0", a_if.running); end
    a_ticks(10);
    checks++; if (cnt_a() !== 28'h0001235) begin errors++; $display("FAIL pause_hold got %h exp %h", cnt_a(), 28'h0001235); end
    a_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_a() !== 28'h0001235) begin errors++; $display("FAIL resume_tick_uncounted got %h exp %h", cnt_a(), 28'h0001235); end
    checks++; if (a_if.running !== 1'b1) begin errors++; $display("FAIL resume_running got %b exp 1", a_if.running); end
    a_ticks(765);
    checks++; if (cnt_a() !== 28'h0002000) begin errors++; $display("FAIL ms_carry got %h exp %h", cnt_a(), 28'h0002000); end
  endtask

  task automatic test_clear();
    a_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL clear_count got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL clear_running got %b exp 0", a_if.running); end
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    a_ticks(500);
    checks++; if (cnt_a() !== 28'h0000500) begin errors++; $display("FAIL run_500 got %h exp %h", cnt_a(), 28'h0000500); end
    a_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL clear_ss_count got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL clear_ss_running got %b exp 0", a_if.running); end
    checks++; if (a_if.ovf !== 1'b0) begin errors++; $display("FAIL clear_ss_ovf got %b exp 0", a_if.ovf); end
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    a_ticks(3210);
    checks++; if (cnt_a() !== 28'h0003210) begin errors++; $display("FAIL run_3210 got %h exp %h", cnt_a(), 28'h0003210); end
    @(negedge clk);
    rst_a = 1'b0; a_if.tick_ms = 1'b1; a_if.start_stop = 1'b1;
    @(negedge clk);
    rst_a = 1'b1; a_if.tick_ms = 1'b0; a_if.start_stop = 1'b0;
    checks++; if (cnt_a() !== 28'h0000000) begin errors++; $display("FAIL midrun_reset got %h exp %h", cnt_a(), 28'h0000000); end
    checks++; if (a_if.running !== 1'b0) begin errors++; $display("FAIL midrun_reset_running got %b exp 0", a_if.running); end
  endtask

  task automatic test_lap();
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    a_ticks(100);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_ticks(400);
`ifdef LAP_HOLD_EN
    checks++; if (cnt_a() !== 28'h0000100) begin errors++; $display("FAIL lap_hold got %h exp %h", cnt_a(), 28'h0000100); end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt_a() !== 28'h0000500) begin errors++; $display("FAIL lap_release got %h exp %h", cnt_a(), 28'h0000500); end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_ticks(5);
    a_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    a_ticks(7);
    checks++; if (cnt_a() !== 28'h0000007) begin errors++; $display("FAIL lap_clear_idle got %h exp %h", cnt_a(), 28'h0000007); end
`else
    checks++; if (cnt_a() !== 28'h0000500) begin errors++; $display("FAIL lap_ignored got %h exp %h", cnt_a(), 28'h0000500); end
`endif
    checks++; if (a_if.running !== 1'b1) begin errors++; $display("FAIL lap_running got %b exp 1", a_if.running); end
  endtask

  task automatic test_saturation();
    rst_b = 1'b0;
    repeat (2) @(negedge clk_b);
    rst_b = 1'b1;
    b_cycle(1'b0, 1'b1, 1'b0);
    b_ticks(59999);
    checks++; if (cnt_b() !== 28'h0059999) begin errors++; $display("FAIL pre_minute got %h exp %h", cnt_b(), 28'h0059999); end
    b_ticks(1);
    checks++; if (cnt_b() !== 28'h0100000) begin errors++; $display("FAIL minute_carry got %h exp %h", cnt_b(), 28'h0100000); end
    b_ticks(59999);
    checks++; if (cnt_b() !== 28'h0159999) begin errors++; $display("FAIL at_max got %h exp %h", cnt_b(), 28'h0159999); end
    checks++; if (b_if.ovf !== 1'b0) begin errors++; $display("FAIL at_max_ovf got %b exp 0", b_if.ovf); end
    b_ticks(1);
    checks++; if (cnt_b() !== 28'h0159999) begin errors++; $display("FAIL sat_hold got %h exp %h", cnt_b(), 28'h0159999); end
    checks++; if (b_if.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", b_if.ovf); end
    checks++; if (b_if.running !== 1'b0) begin errors++; $display("FAIL sat_running got %b exp 0", b_if.running); end
    b_cycle(1'b0, 1'b1, 1'b0);
    b_ticks(3);
    checks++; if (b_if.running !== 1'b0) begin errors++; $display("FAIL sat_restart_running got %b exp 0", b_if.running); end
    checks++; if (cnt_b() !== 28'h0159999) begin errors++; $display("FAIL sat_restart_count got %h exp %h", cnt_b(), 28'h0159999); end
    b_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (cnt_b() !== 28'h0000000) begin errors++; $display("FAIL sat_clear_count got %h exp %h", cnt_b(), 28'h0000000); end
    checks++; if (b_if.ovf !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf got %b exp 0", b_if.ovf); end
  endtask

  initial begin
    a_if.tick_ms = 1'b0; a_if.start_stop = 1'b0; a_if.clear = 1'b0; a_if.lap = 1'b0;
    b_if.tick_ms = 1'b0; b_if.start_stop = 1'b0; b_if.clear = 1'b0; b_if.lap = 1'b0;
    test_reset();
    test_run_pause();
    test_clear();
    test_lap();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
